pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Control end of the pipeline-latch protocol. It drives the update/flush pair on every stage latch (fetch/decode, decode/execute, execute/memory, memory/writeback) and the PC enable.
- Inputs are cache hit strobes, branch/jump resolution and load-use detection.
- Sits beside the datapath in the single-cycle-issue 5-stage MIPS core, one instance per core.

Parameters:
- CNT_W, 32, width of the stall and flush performance counters.
- LU_BUBBLES, 1, number of bubble cycles inserted on a load-use hazard (1..3).

Ports:
- CLK  in  1  core clock
- nRST  in  1  synchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- em_mem_req  in  1  execute/memory latch holds a load or store (dREN|dWEN)
- de_mem_to_reg  in  1  decode/execute latch holds a load
- de_rt  in  5  destination of the load in decode/execute
- fd_rs  in  5  rs of the instruction in fetch/decode
- fd_rt  in  5  rt of the instruction in fetch/decode
- ex_redirect  in  1  taken branch, jump, jr or jal resolved in execute
- mw_halt  in  1  halt reached the memory/writeback latch
- pc_en  out  1  PC register load enable
- fd_update, de_update, em_update, mw_update  out  1 each  latch load enable
- fd_flush, de_flush, em_flush, mw_flush  out  1 each  latch clear-to-NOP
- halted  out  1  sticky halt
- stall_cnt  out  CNT_W  cycles with pc_en=0 while not halted
- flush_cnt  out  CNT_W  redirect flushes performed

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- State register: RUN, LU_STALL, MEM_WAIT, HALT. Bubble counter is 2 bits.
- Outputs are combinational from state and inputs. State and counters update on the rising CLK edge.
- Reset (nRST=0 at the edge): state=RUN, bubble count=0, halted=0, both counters=0.
- While reset is asserted, all update=0, all flush=1 and pc_en=0. This holds regardless of other inputs, including reset asserted in mid-stall.
- Load-use hazard is lu = de_mem_to_reg & (de_rt!=0) & (de_rt==fd_rs | de_rt==fd_rt).
- Memory stall is ms = em_mem_req & ~dhit.
- Priority, highest first: HALT > ms > ex_redirect > lu > ~ihit.
- RUN:
  - ms: all update=0, no flush; next state MEM_WAIT.
  - else ex_redirect: all update=1, fd_flush=1, de_flush=1, pc_en=1; flush_cnt++. The PC mux takes the target.
  - else lu: pc_en=0, fd_update=0, de_flush=1, em/mw update=1; bubble count=LU_BUBBLES-1; if LU_BUBBLES>1, next state LU_STALL.
  - else ~ihit: pc_en=0, fd_update=0, de_flush=1, downstream latches update.
  - else: everything updates, no flushes.
- LU_STALL: same outputs as the RUN lu case. Bubble count decrements; return to RUN when the count reaches 0. ms pre-empts to MEM_WAIT with the bubble count held.
- MEM_WAIT: all update=0 until dhit=1. On dhit=1 all latches update, and the next state is LU_STALL if the bubble count is >0, else RUN.
- mw_halt=1 in any state: next state HALT. mw_update=1 that cycle so the halt retires.
- HALT: halted=1, pc_en=0, all update=0, no flush. Left only by reset.
- update and flush on the same latch in the same cycle: flush wins, and the latch loads NOP.
- stall_cnt increments every cycle with pc_en=0 in a non-HALT state, outside reset. Both counters saturate at all-ones and do not wrap.
- ex_redirect arriving during MEM_WAIT is ignored until the wait ends. The latch holds, so it is re-presented.

Decomposition:
- Add hz_state_t (2-bit enum RUN/LU_STALL/MEM_WAIT/HALT) to my_types_pkg.
- Add latch_ctrl_t (a packed update/flush pair) to my_types_pkg.
- Sub-module sat_counter (width-parameterised saturating incrementer), instantiated twice.

Test Plan:
- Reset asserted with ihit=1, ex_redirect=1: all update=0, all flush=1, pc_en=0. After release, state=RUN and counters=0.
- lw $5 in decode/execute with fd_rs=5, LU_BUBBLES=2: pc_en=0 for 2 cycles, de_flush=1 both cycles, stall_cnt=2.
- lu with de_rt=0: no stall; pc_en=1.
- em_mem_req=1, dhit held low 3 cycles then 1: all update=0 for 3 cycles, then all update=1; stall_cnt=3.
- ex_redirect and lu in the same cycle: fd_flush=de_flush=1, pc_en=1, flush_cnt=1, no stall.
- mw_halt=1 during MEM_WAIT: next cycle halted=1 and pc_en=0. Driving ihit/dhit/ex_redirect for 10 cycles changes nothing; halted=1 persists until nRST=0.

Source files
------------

// File: rtl/my_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : my_types_pkg
// Description : Shared types for the pipeline hazard controller: controller
//               state encoding, the per-latch update/flush pair and the
//               load-use hazard detector.
// Revision    : 1.0 - initial release
// ============================================================================
package my_types_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LU_STALL = 2'd1,
        HZ_MEM_WAIT = 2'd2,
        HZ_HALT     = 2'd3
    } hz_state_t;

    // Control pair for one pipeline latch. When both bits are set, the
    // latch loads a NOP, so flush takes precedence over update.
    typedef struct packed {
        logic update;
        logic flush;
    } latch_ctrl_t;

    localparam latch_ctrl_t LC_HOLD  = '{update: 1'b0, flush: 1'b0};
    localparam latch_ctrl_t LC_LOAD  = '{update: 1'b1, flush: 1'b0};
    localparam latch_ctrl_t LC_NOP   = '{update: 1'b1, flush: 1'b1};
    localparam latch_ctrl_t LC_CLEAR = '{update: 1'b0, flush: 1'b1};

    // A load in decode/execute feeds a source register of the instruction in
    // fetch/decode. Register $0 never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       mem_to_reg,
        input logic [4:0] ld_rt,
        input logic [4:0] rs,
        input logic [4:0] rt
    );
        return mem_to_reg && (ld_rt != 5'd0) && ((ld_rt == rs) || (ld_rt == rt));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Width-parameterised counter that increments on i_inc and
//               sticks at all-ones instead of wrapping.
// Ports       : i_clk   - clock
//               i_rst_n - synchronous active-low clear
//               i_inc   - increment request
//               o_count - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + C_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard/stall controller for a 5-stage MIPS pipeline. Drives
//               the update/flush pair of every stage latch and the PC enable
//               from cache hit strobes, branch resolution and load-use
//               detection. Counts stall cycles and redirect flushes.
// Ports       : CLK, nRST          - clock, synchronous active-low reset
//               ihit, dhit          - instruction / data access complete
//               em_mem_req          - memory op held in execute/memory latch
//               de_mem_to_reg, de_rt- load and its destination in dec/exe
//               fd_rs, fd_rt        - sources of the instruction in fet/dec
//               ex_redirect         - taken control transfer resolved in exe
//               mw_halt             - halt reached memory/writeback latch
//               pc_en               - PC load enable
//               *_update, *_flush   - per-latch load enable / clear-to-NOP
//               halted              - sticky halt indication
//               stall_cnt,flush_cnt - saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import my_types_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int LU_BUBBLES = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             em_mem_req,
    input  logic             de_mem_to_reg,
    input  logic [4:0]       de_rt,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             ex_redirect,
    input  logic             mw_halt,
    output logic             pc_en,
    output logic             fd_update,
    output logic             de_update,
    output logic             em_update,
    output logic             mw_update,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Bubbles still owed after the first stall cycle of a load-use hazard.
    localparam logic [1:0] C_LU_RELOAD = 2'(LU_BUBBLES - 1);

    hz_state_t   state_q;
    hz_state_t   state_d;
    logic [1:0]  bubble_q;
    logic [1:0]  bubble_d;

    logic        w_lu;
    logic        w_ms;
    logic        w_pc_en;
    logic        w_redirect_taken;
    logic        w_stall_inc;
    latch_ctrl_t w_fd;
    latch_ctrl_t w_de;
    latch_ctrl_t w_em;
    latch_ctrl_t w_mw;

    assign w_lu = load_use_hazard(de_mem_to_reg, de_rt, fd_rs, fd_rt);
    assign w_ms = em_mem_req & ~dhit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= HZ_RUN;
            bubble_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        bubble_d = bubble_q;
        if (mw_halt || (state_q == HZ_HALT)) begin
            state_d = HZ_HALT;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (w_ms) begin
                        state_d = HZ_MEM_WAIT;
                    end else if (ex_redirect) begin
                        state_d = HZ_RUN;
                    end else if (w_lu) begin
                        bubble_d = C_LU_RELOAD;
                        if (LU_BUBBLES > 1) begin
                            state_d = HZ_LU_STALL;
                        end
                    end
                end
                HZ_LU_STALL: begin
                    // A memory stall freezes the bubble count; it resumes
                    // once the data access completes.
                    if (w_ms) begin
                        state_d = HZ_MEM_WAIT;
                    end else begin
                        bubble_d = bubble_q - 2'd1;
                        if (bubble_q <= 2'd1) begin
                            state_d = HZ_RUN;
                        end
                    end
                end
                HZ_MEM_WAIT: begin
                    if (dhit) begin
                        state_d = (bubble_q != 2'd0) ? HZ_LU_STALL : HZ_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_en          = 1'b0;
        w_redirect_taken = 1'b0;
        w_fd             = LC_HOLD;
        w_de             = LC_HOLD;
        w_em             = LC_HOLD;
        w_mw             = LC_HOLD;
        if (!nRST) begin
            // Reset wins over everything, including an in-flight stall.
            w_fd = LC_CLEAR;
            w_de = LC_CLEAR;
            w_em = LC_CLEAR;
            w_mw = LC_CLEAR;
        end else if (state_q == HZ_HALT) begin
            w_pc_en = 1'b0;
        end else if (mw_halt) begin
            // Freeze the front of the pipe but let the halt itself retire.
            w_mw = LC_LOAD;
        end else begin
            case (state_q)
                HZ_RUN: begin
                    if (w_ms) begin
                        w_pc_en = 1'b0;
                    end else if (ex_redirect) begin
                        w_pc_en          = 1'b1;
                        w_redirect_taken = 1'b1;
                        w_fd             = LC_NOP;
                        w_de             = LC_NOP;
                        w_em             = LC_LOAD;
                        w_mw             = LC_LOAD;
                    end else if (w_lu || !ihit) begin
                        // Hold PC and fetch/decode, inject a bubble behind.
                        w_de = LC_NOP;
                        w_em = LC_LOAD;
                        w_mw = LC_LOAD;
                    end else begin
                        w_pc_en = 1'b1;
                        w_fd    = LC_LOAD;
                        w_de    = LC_LOAD;
                        w_em    = LC_LOAD;
                        w_mw    = LC_LOAD;
                    end
                end
                HZ_LU_STALL: begin
                    if (!w_ms) begin
                        w_de = LC_NOP;
                        w_em = LC_LOAD;
                        w_mw = LC_LOAD;
                    end
                end
                HZ_MEM_WAIT: begin
                    // A redirect seen here is dropped; the execute latch is
                    // frozen so it is presented again after the wait.
                    if (dhit) begin
                        w_pc_en = 1'b1;
                        w_fd    = LC_LOAD;
                        w_de    = LC_LOAD;
                        w_em    = LC_LOAD;
                        w_mw    = LC_LOAD;
                    end
                end
                default: begin
                    w_pc_en = 1'b0;
                end
            endcase
        end
    end

    assign w_stall_inc = nRST & ~w_pc_en & (state_q != HZ_HALT);

    assign pc_en     = w_pc_en;
    assign fd_update = w_fd.update;
    assign de_update = w_de.update;
    assign em_update = w_em.update;
    assign mw_update = w_mw.update;
    assign fd_flush  = w_fd.flush;
    assign de_flush  = w_de.flush;
    assign em_flush  = w_em.flush;
    assign mw_flush  = w_mw.flush;
    assign halted    = nRST & (state_q == HZ_HALT);

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_inc   (w_stall_inc),
        .o_count (stall_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_inc   (w_redirect_taken),
        .o_count (flush_cnt)
    );

endmodule
`default_nettype wire
